// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus of the branch predictor: the stage-1 lookup, the stage-4
// training port, the misprediction flag and the performance counters.
interface branch_predictor_if #(
    parameter int IDXW = 4,
    parameter int XLEN = 32
);
    // stage-1 lookup
    logic [XLEN-1:0] pcs1;
    logic            predTakens1;
    logic [XLEN-1:0] predTargets1;
    // stage-4 resolution / training
    logic            updEns4;
    logic [XLEN-1:0] updPcs4;
    logic            updTakens4;
    logic [XLEN-1:0] updTargets4;
    logic            updUnconds4;
    logic            updPredTakens4;
    logic [XLEN-1:0] updPredTargets4;
    logic            mispredicts4;
    // performance counters
    logic [31:0]     ctrlCount;
    logic [31:0]     missCount;

    // pipeline side: drives PCs and resolutions, consumes predictions
    modport master (
        output pcs1, updEns4, updPcs4, updTakens4, updTargets4, updUnconds4,
               updPredTakens4, updPredTargets4,
        input  predTakens1, predTargets1, mispredicts4, ctrlCount, missCount
    );

    // predictor side
    modport slave (
        input  pcs1, updEns4, updPcs4, updTakens4, updTargets4, updUnconds4,
               updPredTakens4, updPredTargets4,
        output predTakens1, predTargets1, mispredicts4, ctrlCount, missCount
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational from pcs1; training happens on the rising edge when
// a control transfer resolves in stage 4. No bypass: a same-cycle lookup sees
// the pre-update entry.
module branch_predictor #(
    parameter int IDXW = 4,
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << IDXW;
    localparam int TAGW    = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_r;
    logic [TAGW-1:0]    tag_r    [ENTRIES];
    logic [XLEN-1:0]    target_r [ENTRIES];
    logic [1:0]         ctr_r    [ENTRIES];
    logic [31:0]        ctrl_count_r;
    logic [31:0]        miss_count_r;

    logic [IDXW-1:0]    look_idx_s;
    logic               look_hit_s;
    logic               pred_taken_s;
    logic [XLEN-1:0]    pred_target_s;
    logic [IDXW-1:0]    upd_idx_s;
    logic               upd_hit_s;
    logic               upd_taken_s;
    logic               mispredict_s;
    logic               unused_pc_bits_s;

    // saturating increment of a 2-bit counter
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // saturating decrement of a 2-bit counter
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // the low PC bits never select anything (instructions are word aligned)
    assign unused_pc_bits_s = ^{bus.pcs1[1:0], bus.updPcs4[1:0]};

    // stage-1 lookup: hit and counter MSB predicts taken, else fall through
    always_comb begin
        look_idx_s    = bus.pcs1[IDXW+1:2];
        look_hit_s    = valid_r[look_idx_s] && (tag_r[look_idx_s] == bus.pcs1[XLEN-1:IDXW+2]);
        pred_taken_s  = 1'b0;
        pred_target_s = bus.pcs1 + XLEN'(4);
        if (look_hit_s && ctr_r[look_idx_s][1]) begin
            pred_taken_s  = 1'b1;
            pred_target_s = target_r[look_idx_s];
        end else begin
            pred_taken_s  = 1'b0;
        end
    end

    // stage-4 resolution: hit check and misprediction (direction or target)
    always_comb begin
        upd_idx_s    = bus.updPcs4[IDXW+1:2];
        upd_hit_s    = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == bus.updPcs4[XLEN-1:IDXW+2]);
        upd_taken_s  = bus.updTakens4 | bus.updUnconds4;
        mispredict_s = 1'b0;
        if (bus.updEns4) begin
            mispredict_s = (upd_taken_s != bus.updPredTakens4) ||
                           (upd_taken_s && bus.updPredTakens4 &&
                            (bus.updTargets4 != bus.updPredTargets4));
        end else begin
            mispredict_s = 1'b0;
        end
    end

    assign bus.predTakens1  = pred_taken_s;
    assign bus.predTargets1 = pred_target_s;
    assign bus.mispredicts4 = mispredict_s;
    assign bus.ctrlCount    = ctrl_count_r;
    assign bus.missCount    = miss_count_r;

    // table training and performance counting on each resolved transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= 2'b01;
            end
            ctrl_count_r <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (bus.updEns4) begin
            ctrl_count_r <= ctrl_count_r + 32'd1;
            if (mispredict_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
            if (upd_hit_s) begin
                if (bus.updUnconds4) begin
                    ctr_r[upd_idx_s]    <= 2'b11;
                    target_r[upd_idx_s] <= bus.updTargets4;
                end else if (bus.updTakens4) begin
                    ctr_r[upd_idx_s]    <= sat_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= bus.updTargets4;
                end else begin
                    ctr_r[upd_idx_s]    <= sat_dec(ctr_r[upd_idx_s]);
                end
            end else if (upd_taken_s) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= bus.updPcs4[XLEN-1:IDXW+2];
                target_r[upd_idx_s] <= bus.updTargets4;
                ctr_r[upd_idx_s]    <= bus.updUnconds4 ? 2'b11 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    branch_predictor_if #(.IDXW(4), .XLEN(32)) bus ();

    branch_predictor #(.IDXW(4), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // present a resolution at the negedge; caller samples before/after edge
    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic uncond, input logic ptaken, input logic [31:0] ptgt);
        bus.updEns4         = 1'b1;
        bus.updPcs4         = pc;
        bus.updTakens4      = taken;
        bus.updTargets4     = tgt;
        bus.updUnconds4     = uncond;
        bus.updPredTakens4  = ptaken;
        bus.updPredTargets4 = ptgt;
    endtask

    // clock the pending update in and return to the negedge with enable low
    task automatic commit;
        @(posedge clk);
        #1;
        bus.updEns4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.pcs1 = 32'h100;
        bus.updEns4 = 1'b0;
        bus.updPcs4 = 32'h0;
        bus.updTakens4 = 1'b0;
        bus.updTargets4 = 32'h0;
        bus.updUnconds4 = 1'b0;
        bus.updPredTakens4 = 1'b0;
        bus.updPredTargets4 = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check_val("rst_taken",  {31'd0, bus.predTakens1}, 32'd0);
        check_val("rst_target", bus.predTargets1, 32'h104);
        check_val("rst_ctrl",   bus.ctrlCount, 32'd0);
        check_val("rst_miss",   bus.missCount, 32'd0);
        check_val("rst_ctr",    {30'd0, dut.ctr_r[0]}, 32'd1);

        // first taken branch allocates with ctr=10
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        #1 check_val("alloc_mis", {31'd0, bus.mispredicts4}, 32'd1);
        commit();
        check_val("alloc_taken",  {31'd0, bus.predTakens1}, 32'd1);
        check_val("alloc_target", bus.predTargets1, 32'h80);
        check_val("alloc_ctr",    {30'd0, dut.ctr_r[0]}, 32'd2);
        check_val("alloc_ctrl",   bus.ctrlCount, 32'd1);
        check_val("alloc_miss",   bus.missCount, 32'd1);

        // not taken: 10 -> 01, prediction flips to not taken
        drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        #1 check_val("nt1_mis", {31'd0, bus.mispredicts4}, 32'd1);
        commit();
        check_val("nt1_taken",  {31'd0, bus.predTakens1}, 32'd0);
        check_val("nt1_target", bus.predTargets1, 32'h104);
        check_val("nt1_ctr",    {30'd0, dut.ctr_r[0]}, 32'd1);

        // not taken again, correctly predicted: 01 -> 00
        drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        #1 check_val("nt2_mis", {31'd0, bus.mispredicts4}, 32'd0);
        commit();
        check_val("nt2_ctr",  {30'd0, dut.ctr_r[0]}, 32'd0);
        check_val("nt2_ctrl", bus.ctrlCount, 32'd3);
        check_val("nt2_miss", bus.missCount, 32'd2);

        // taken: 00 -> 01, still predicted not taken
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        commit();
        check_val("t1_ctr",   {30'd0, dut.ctr_r[0]}, 32'd1);
        check_val("t1_taken", {31'd0, bus.predTakens1}, 32'd0);

        // taken again: 01 -> 10, predicted taken to 0x80
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
        commit();
        check_val("t2_taken",  {31'd0, bus.predTakens1}, 32'd1);
        check_val("t2_target", bus.predTargets1, 32'h80);

        // aliasing: 0x140 maps to the same index and replaces the tag
        drive_upd(32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 32'h144);
        commit();
        check_val("alias_old_taken",  {31'd0, bus.predTakens1}, 32'd0);
        check_val("alias_old_target", bus.predTargets1, 32'h104);
        bus.pcs1 = 32'h140;
        #1;
        check_val("alias_new_taken",  {31'd0, bus.predTakens1}, 32'd1);
        check_val("alias_new_target", bus.predTargets1, 32'h200);
        check_val("alias_ctrl", bus.ctrlCount, 32'd6);
        check_val("alias_miss", bus.missCount, 32'd5);

        // unconditional re-allocation of 0x100 sets ctr=11
        bus.pcs1 = 32'h100;
        drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 1'b0, 32'h104);
        commit();
        check_val("jal_ctr",    {30'd0, dut.ctr_r[0]}, 32'd3);
        check_val("jal_target", bus.predTargets1, 32'h80);

        // same-cycle lookup/update: old target this cycle, new next cycle;
        // right direction with wrong target is a mispredict
        drive_upd(32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 32'h80);
        #1;
        check_val("same_mis",    {31'd0, bus.mispredicts4}, 32'd1);
        check_val("same_before", bus.predTargets1, 32'h80);
        commit();
        check_val("same_after",  bus.predTargets1, 32'h300);
        check_val("same_ctr",    {30'd0, dut.ctr_r[0]}, 32'd3);

        // fully correct prediction
        drive_upd(32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
        #1 check_val("ok_mis", {31'd0, bus.mispredicts4}, 32'd0);
        commit();
        check_val("ok_ctrl", bus.ctrlCount, 32'd9);
        check_val("ok_miss", bus.missCount, 32'd7);

        // enable low: no mispredict, no state change
        drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        bus.updEns4 = 1'b0;
        #1 check_val("idle_mis", {31'd0, bus.mispredicts4}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("idle_ctrl", bus.ctrlCount, 32'd9);
        check_val("idle_ctr",  {30'd0, dut.ctr_r[0]}, 32'd3);

        // counter wrap
        force dut.ctrl_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.ctrl_count_r;
        check_val("wrap_pre", bus.ctrlCount, 32'hFFFF_FFFF);
        drive_upd(32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
        commit();
        check_val("wrap_ctrl", bus.ctrlCount, 32'd0);
        check_val("wrap_miss", bus.missCount, 32'd7);

        // asynchronous reset in the middle of an update cycle
        drive_upd(32'h140, 1'b1, 32'h999, 1'b0, 1'b0, 32'h144);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_taken",  {31'd0, bus.predTakens1}, 32'd0);
        check_val("arst_target", bus.predTargets1, 32'h104);
        check_val("arst_ctrl",   bus.ctrlCount, 32'd0);
        check_val("arst_miss",   bus.missCount, 32'd7 - 32'd7);
        @(posedge clk);
        #1;
        bus.updEns4 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.pcs1 = 32'h140;
        #1;
        check_val("arst_discard_taken",  {31'd0, bus.predTakens1}, 32'd0);
        check_val("arst_discard_target", bus.predTargets1, 32'h144);
        check_val("arst_discard_ctr",    {30'd0, dut.ctr_r[0]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
